prog_counter: RTL and testbench

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter.sv | 75 +++++++
 tb/tb_prog_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
// Programmable up/down modulo counter with prescaler, wrap/saturate modes, terminal-count pulse and sticky overflow.
// All outputs registered: count/tc/ovf reflect the tick or load of the previous rising edge; no backpressure.
module prog_counter #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             sat_mode,
    input  logic [PSC_W-1:0] prescale,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [PSC_W-1:0] psc;
    logic             tick;
    logic             at_bound;
    logic [WIDTH-1:0] load_cnt;
    logic [WIDTH-1:0] tick_cnt;

    always_comb begin
        tick     = enable & ~load & (psc >= prescale);
        at_bound = up_dn ? (count >= mod_max) : (count == '0);
        load_cnt = (load_val > mod_max) ? mod_max : load_val;
        tick_cnt = count;
        if (up_dn) begin
            if (at_bound)
                tick_cnt = sat_mode ? mod_max : '0;
            else
                tick_cnt = count + WIDTH'(1);
        end else begin
            if (at_bound)
                tick_cnt = sat_mode ? '0 : mod_max;
            // A lowered mod_max pulls a down-count straight back into range.
            else if (count > mod_max)
                tick_cnt = mod_max;
            else
                tick_cnt = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc   <= '0;
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load)
                psc <= '0;
            else if (enable)
                psc <= (psc >= prescale) ? '0 : psc + PSC_W'(1);

            if (load)
                count <= load_cnt;
            else if (tick)
                count <= tick_cnt;

            tc <= tick & at_bound;

            if (tick & at_bound)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Randomized and directed bench for prog_counter: a reference model pushes expected outputs,
// a monitor pops and compares them after each rising edge.
module tb_prog_counter;

    localparam int WIDTH = 8;
    localparam int PSC_W = 4;

    typedef struct packed {
        logic [31:0] cnt;
        logic        tc;
        logic        ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_max;
    logic             sat_mode;
    logic [PSC_W-1:0] prescale;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference state kept as plain integers
    int m_cnt = 0;
    int m_psc = 0;
    int m_ovf = 0;

    prog_counter #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .mod_max  (mod_max),
        .sat_mode (sat_mode),
        .prescale (prescale),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: every rising edge produces one output sample
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", int'(count), int'(e.cnt));
                chk("tc", int'(tc), int'(e.tc));
                chk("ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    // One clock cycle of stimulus; caller is positioned between edges.
    task automatic cyc(input bit en, input bit ud, input bit ld, input int lv,
                       input int mm, input bit sat, input int pre, input bit clr);
        int   m_tc;
        bit   tick;
        exp_t e;
        enable   = en;
        up_dn    = ud;
        load     = ld;
        load_val = lv[WIDTH-1:0];
        mod_max  = mm[WIDTH-1:0];
        sat_mode = sat;
        prescale = pre[PSC_W-1:0];
        clr_ovf  = clr;

        m_tc = 0;
        tick = 0;
        if (ld) begin
            m_cnt = (lv < mm) ? lv : mm;
            m_psc = 0;
        end else if (en) begin
            if (m_psc >= pre) begin
                tick  = 1;
                m_psc = 0;
            end else begin
                m_psc = m_psc + 1;
            end
        end
        if (tick) begin
            if (ud) begin
                if (m_cnt < mm) m_cnt = m_cnt + 1;
                else begin m_tc = 1; m_cnt = sat ? mm : 0; end
            end else begin
                if (m_cnt == 0) begin m_tc = 1; m_cnt = sat ? 0 : mm; end
                else m_cnt = (m_cnt - 1 < mm) ? m_cnt - 1 : mm;
            end
        end
        if (m_tc == 1) m_ovf = 1;
        else if (clr) m_ovf = 0;

        e.cnt = 32'(m_cnt);
        e.tc  = m_tc[0];
        e.ovf = m_ovf[0];
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Reset held for a whole cycle while inputs toggle randomly
    task automatic rst_cyc();
        exp_t e;
        reset    = 1'b1;
        enable   = 1'($urandom);
        load     = 1'($urandom);
        load_val = WIDTH'($urandom);
        clr_ovf  = 1'($urandom);
        m_cnt = 0; m_psc = 0; m_ovf = 0;
        e = '0;
        exp_q.push_back(e);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int mm, pre, lv;
        bit sat;
        reset = 1'b1; enable = 0; up_dn = 1; load = 0; load_val = '0;
        mod_max = '0; sat_mode = 0; prescale = '0; clr_ovf = 0;
        #3;
        chk("reset_count", int'(count), 0);
        chk("reset_tc", int'(tc), 0);
        chk("reset_ovf", int'(ovf), 0);
        @(negedge clk);
        reset = 1'b0;

        // Full up-wrap sweep, every cycle a tick
        for (int i = 0; i < 256; i++) cyc(1, 1, 0, 0, 255, 0, 0, 0);
        chk("sweep_end_count", int'(count), 0);
        chk("sweep_end_ovf", int'(ovf), 1);

        // Prescale 3, modulo 10, with an enable gap
        cyc(0, 1, 1, 0, 9, 0, 3, 1);
        for (int i = 0; i < 30; i++) cyc(1, 1, 0, 0, 9, 0, 3, 0);
        for (int i = 0; i < 5; i++)  cyc(0, 1, 0, 0, 9, 0, 3, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 0, 9, 0, 3, 0);

        // Down, saturating, from 2; clear of ovf collides with boundary tick
        cyc(0, 0, 1, 2, 9, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 9, 1, 0, 0);
        cyc(1, 0, 0, 0, 9, 1, 0, 1);
        chk("sat_clr_collide_ovf", int'(ovf), 1);
        chk("sat_hold_count", int'(count), 0);

        // Load clamps to mod_max; load beats a coincident tick
        cyc(0, 1, 1, 200, 5, 0, 0, 1);
        chk("load_clamp_count", int'(count), 5);
        cyc(1, 1, 1, 3, 5, 0, 0, 0);
        chk("load_vs_tick_count", int'(count), 3);
        chk("load_vs_tick_tc", int'(tc), 0);

        // mod_max lowered below current count
        cyc(0, 1, 1, 7, 9, 0, 0, 0);
        cyc(1, 1, 0, 0, 3, 0, 0, 0);
        chk("lowered_max_count", int'(count), 0);
        chk("lowered_max_tc", int'(tc), 1);

        // Asynchronous reset between edges at 0x5A
        cyc(0, 1, 1, 'h5A, 255, 0, 2, 0);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_count", int'(count), 0);
        #1 reset = 1'b0;
        m_cnt = 0; m_psc = 0; m_ovf = 0;
        cyc(1, 1, 0, 0, 255, 0, 2, 0);
        cyc(1, 1, 0, 0, 255, 0, 2, 0);
        chk("post_reset_no_tick", int'(count), 0);
        cyc(1, 1, 0, 0, 255, 0, 2, 0);
        chk("post_reset_first_tick", int'(count), 1);

        // Randomized traffic including mod_max=0, prescale changes and resets
        mm = 12; pre = 1; sat = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0)
                mm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255));
            if ($urandom_range(0, 29) == 0) pre = int'($urandom_range(0, 4));
            if ($urandom_range(0, 24) == 0) sat = 1'($urandom);
            lv = int'($urandom_range(0, 255));
            if ($urandom_range(0, 299) == 0)
                rst_cyc();
            else
                cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                    lv, mm, sat, pre, $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
